// File: rtl/mux2_arb_pkg.sv
// Shared types and default parameters for the 2:1 round-robin mux arbiter.
package mux2_arb_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake and data bundle between two requesters, the arbiter and the downstream sink.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = mux2_arb_pkg::WIDTH_DEF
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             gnt0;
  logic             gnt1;
  logic             s;
  logic             e;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;

  modport slave (
    input  req0, req1, i0, i1, y_ready,
    output gnt0, gnt1, s, e, y, y_valid
  );

  modport master (
    output req0, req1, i0, i1, y_ready,
    input  gnt0, gnt1, s, e, y, y_valid
  );
endinterface

// File: rtl/mux2_rr_arbiter_datapath.sv
// Enabled 2:1 multiplexer; output is forced to zero when disabled.
module mux2_datapath #(
  parameter int WIDTH = mux2_arb_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             e,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = !e ? '0 : (s ? i1 : i0);
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-bounded controller driving the shared mux from registered select/enable.
//   state | meaning
//   IDLE  | no grant, mux disabled
//   OWN0  | requester 0 owns the output
//   OWN1  | requester 1 owns the output
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic               clk,
  input logic               rst,
  mux2_rr_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_e         state_q, state_d;
  req_idx_t       last_q, last_d;
  logic           s_q, s_d;
  logic           e_q, e_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           y_valid;
  logic           xfer;
  logic           burst_done;

  assign y_valid    = e_q & (s_q ? bus.req1 : bus.req0);
  assign xfer       = y_valid & bus.y_ready;
  assign burst_done = xfer && ((int'(cnt_q) + 1) >= MAX_BURST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0: begin
        if (!bus.req0)                    state_d = bus.req1 ? OWN1 : IDLE;
        else if (burst_done && bus.req1)  state_d = OWN1;
      end
      OWN1: begin
        if (!bus.req1)                    state_d = bus.req0 ? OWN0 : IDLE;
        else if (burst_done && bus.req0)  state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered mux controls follow the next state so they are valid right after the grant edge.
  always_comb begin
    last_d = last_q;
    s_d    = s_q;
    e_d    = e_q;
    gnt0_d = gnt0_q;
    gnt1_d = gnt1_q;
    cnt_d  = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      unique case (state_d)
        OWN0: begin
          last_d = 1'b0;
          s_d    = 1'b0;
          e_d    = 1'b1;
          gnt0_d = 1'b1;
          gnt1_d = 1'b0;
        end
        OWN1: begin
          last_d = 1'b1;
          s_d    = 1'b1;
          e_d    = 1'b1;
          gnt0_d = 1'b0;
          gnt1_d = 1'b1;
        end
        default: begin
          e_d    = 1'b0;
          gnt0_d = 1'b0;
          gnt1_d = 1'b0;
        end
      endcase
    end else if (xfer && (int'(cnt_q) < MAX_BURST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      e_q     <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      e_q     <= e_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.s       = s_q;
  assign bus.e       = e_q;
  assign bus.y_valid = y_valid;

  mux2_datapath #(.WIDTH(WIDTH)) u_dp (
    .i0 (bus.i0),
    .i1 (bus.i1),
    .e  (e_q),
    .s  (s_q),
    .y  (bus.y)
  );
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter with MAX_BURST=4.
module tb_mux2_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic       g0;
    logic       g1;
    logic       s;
    logic       e;
    logic [7:0] y;
    logic       yv;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic r0, input logic r1, input logic g0, input logic g1,
                              input logic s, input logic e, input logic [7:0] y, input logic yv);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = 8'hA5; v.d1 = 8'h3C; v.rdy = 1'b1;
    v.g0 = g0; v.g1 = g1; v.s = s; v.e = e; v.y = y; v.yv = yv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.y_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [12:0] act_bundle;

  initial begin
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.i0 = 8'h11;
    bus.i1 = 8'h22;
    bus.y_ready = 1'b0;

    // reset with both requests pending, then tie goes to requester 0
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_e", 32'(bus.e), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_yv", 32'(bus.y_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rel_gnt0", 32'(bus.gnt0), 32'd1);
    chk("rel_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rel_s", 32'(bus.s), 32'd0);
    chk("rel_y", 32'(bus.y), 32'h11);

    // single requester with saturation, contention bursts of 4, release and re-grant
    for (int i = 0; i < 6; i++) vecs[i] = mk(1, 0, 1, 0, 0, 1, 8'hA5, 1);
    vecs[6] = mk(1, 1, 0, 1, 1, 1, 8'h3C, 1);
    for (int i = 7; i < 10; i++) vecs[i] = mk(1, 1, 0, 1, 1, 1, 8'h3C, 1);
    for (int i = 10; i < 14; i++) vecs[i] = mk(1, 1, 1, 0, 0, 1, 8'hA5, 1);
    vecs[14] = mk(1, 1, 0, 1, 1, 1, 8'h3C, 1);
    vecs[15] = mk(0, 1, 0, 1, 1, 1, 8'h3C, 1);
    vecs[16] = mk(0, 0, 0, 0, 1, 0, 8'h00, 0);
    vecs[17] = mk(0, 0, 0, 0, 1, 0, 8'h00, 0);
    vecs[18] = mk(1, 0, 1, 0, 0, 1, 8'hA5, 1);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      bus.req0 = vecs[i].r0;
      bus.req1 = vecs[i].r1;
      bus.i0 = vecs[i].d0;
      bus.i1 = vecs[i].d1;
      bus.y_ready = vecs[i].rdy;
      tick();
      act_bundle = {bus.gnt0, bus.gnt1, bus.s, bus.e, bus.y, bus.y_valid};
      chk($sformatf("vec%0d", i), 32'(act_bundle),
          32'({vecs[i].g0, vecs[i].g1, vecs[i].s, vecs[i].e, vecs[i].y, vecs[i].yv}));
    end

    // backpressure at cnt=3 holds the grant, one transfer then handover
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    bus.i0 = 8'h5A;
    bus.i1 = 8'hC3;
    bus.y_ready = 1'b1;
    repeat (4) tick();
    bus.y_ready = 1'b0;
    bus.req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_gnt0_%0d", k), 32'(bus.gnt0), 32'd1);
      chk($sformatf("bp_gnt1_%0d", k), 32'(bus.gnt1), 32'd0);
      chk($sformatf("bp_yv_%0d", k), 32'(bus.y_valid), 32'd1);
      chk($sformatf("bp_y_%0d", k), 32'(bus.y), 32'h5A);
    end
    bus.y_ready = 1'b1;
    tick();
    chk("bp_ho_gnt1", 32'(bus.gnt1), 32'd1);
    chk("bp_ho_gnt0", 32'(bus.gnt0), 32'd0);
    chk("bp_ho_y", 32'(bus.y), 32'hC3);

    // release: y_valid falls with req, grant falls at the next edge
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    bus.i0 = 8'hA5;
    bus.i1 = 8'h3C;
    bus.y_ready = 1'b1;
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("rl_yv_now", 32'(bus.y_valid), 32'd0);
    chk("rl_gnt0_hold", 32'(bus.gnt0), 32'd1);
    tick();
    chk("rl_e_idle", 32'(bus.e), 32'd0);
    chk("rl_gnt0_idle", 32'(bus.gnt0), 32'd0);
    bus.req1 = 1'b1;
    tick();
    chk("rl_gnt1", 32'(bus.gnt1), 32'd1);
    chk("rl_s1", 32'(bus.s), 32'd1);
    chk("rl_y1", 32'(bus.y), 32'h3C);

    // async reset mid-burst in OWN1, then requester 0 wins with a full burst
    do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    bus.i0 = 8'h88;
    bus.i1 = 8'h77;
    bus.y_ready = 1'b1;
    repeat (3) tick();
    bus.req0 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt1", 32'(bus.gnt1), 32'd0);
    chk("ar_e", 32'(bus.e), 32'd0);
    chk("ar_s", 32'(bus.s), 32'd0);
    chk("ar_yv", 32'(bus.y_valid), 32'd0);
    chk("ar_y", 32'(bus.y), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ar_burst0_%0d", k), 32'({bus.gnt0, bus.gnt1}), 32'b10);
    end
    tick();
    chk("ar_ho", 32'({bus.gnt0, bus.gnt1}), 32'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Sequencing controller for the 2:1 enabled multiplexer datapath. Two requesters compete for one shared output. The block arbitrates round-robin with a bounded burst length and drives the mux select and enable from registered state. It presents the muxed word downstream under a valid/ready handshake, so the shared mux becomes a fair, flow-controlled resource.

## Interface
- WIDTH, 8, data width of each input and of the output
- MAX_BURST, 4, maximum consecutive transfers per grant while the other requester waits; legal range is ≥1
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- req0 / req1  input  1  requester asks for the output; held high until its last word transfers
- i0 / i1  input  WIDTH  requester data; must stay stable while the matching req is high and not yet accepted
- gnt0 / gnt1  output  1  registered grant, one-hot or all-zero
- s  output  1  mux select (0 = i0, 1 = i1), registered
- e  output  1  mux enable, registered; high when any grant is active
- y  output  WIDTH  muxed data, equal to (e & ~s) ? i0 : (e & s) ? i1 : 0
- y_valid  output  1  high when e and the owning requester's req are both high
- y_ready  input  1  downstream accepts y this cycle

## Operation
- The state machine has three states: IDLE, OWN0, OWN1. On reset the state is IDLE.
- Transfer occurs on any cycle where y_valid and y_ready are both high.
- last is a 1-bit register holding the requester served most recently. Reset value is 1, so requester 0 wins the first tie.
- cnt counts transfers in the current grant. Width is $clog2(MAX_BURST+1). It increments on each transfer and saturates at MAX_BURST. It clears to 0 on every grant change.

IDLE:
- Only req0 high: go to OWN0.
- Only req1 high: go to OWN1.
- Both high: go to OWN(~last).
- Neither high: stay in IDLE.

OWNx, evaluated in this priority order:
1. reqx low: go to OWN(other) if req(other) is high, else go to IDLE.
2. Transfer, cnt+1 ≥ MAX_BURST, and req(other) high: go to OWN(other). This is a forced handover.
3. Otherwise stay in OWNx.

Register updates:
- On entering OWNx: set last=x, s=x, e=1, gntx=1.
- On entering IDLE: e=0 and both grants=0. s holds its previous value.

Flow-control rule:
- A grant never changes while y_valid is high and y_ready is low.
- A word presented with valid high is never withdrawn; it only leaves via a transfer.

Other rules:
- Requests arriving while the other requester owns the output wait. The block never preempts outside rule 2.
- When reqx drops during OWNx, y_valid drops in the same cycle because it is combinational from req. The grant releases at the next edge.

## Timing
- Reset values: gnt0=gnt1=0, s=0, e=0, y=0, y_valid=0, cnt=0, last=1. Reset takes effect immediately on rst high, with no clock needed.
- Request to grant: 1 cycle. A req sampled high at edge N in IDLE gives gnt, e, s valid after edge N.
- Handover between requesters takes zero bubble cycles. The new owner's word can transfer in the cycle after the last transfer of the previous owner.
- Return to IDLE and re-grant costs 1 idle cycle.
- y and y_valid are combinational from registered s/e and the live req/i inputs. No output register, so no added latency.
- Reset asserted mid-burst: all outputs go to reset values at once. An in-flight word is dropped, and the requester must re-present it.
- When MAX_BURST=1, every transfer triggers a handover if the other requester is waiting, giving strict alternation.

## Structure
- Shared package mux2_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1)
  - the requester index type (1 bit)
  - the default WIDTH and MAX_BURST constants
- The datapath is a sub-module, mux2_datapath (i0, i1, e, s → y), WIDTH-parameterised. The controller instantiates it and contains the FSM, counter and last-served register.

## Test plan
- **Reset:** raise rst with req0=req1=1 → gnt0=gnt1=e=y_valid=0 and y=0. Release rst → gnt0=1, s=0 after the first edge.
- **Single requester:** req0=1, i0=8'hA5, y_ready=1 for 6 cycles with req1=0 → gnt0 stays 1 throughout (no forced switch), y=8'hA5, y_valid=1.
- **Contention, MAX_BURST=4:** both req high, y_ready=1 → grants alternate in runs of 0,0,0,0,1,1,1,1,0…, with zero-bubble handover and no cycle where both grants are high.
- **Backpressure:** y_ready=0 while OWN0 with cnt=3 and req1=1 → grant stays 0, y_valid stays 1, y stable. Raise y_ready → one transfer, then gnt1=1 next cycle.
- **Release:** req0 drops during OWN0 with req1=0 → y_valid=0 in the same cycle, then IDLE with e=0. A later req1 gives gnt1 one cycle after.
- **Async reset mid-burst:** rst pulses between edges during OWN1 with cnt=2 → outputs clear before the next edge, cnt=0, and after release requester 0 wins the tie.
